// File: rtl/seq_pkg.sv
// Shared types and constants for the pulse sequencer: state encoding, class bit
// positions, opcode mask/match patterns and default end steps.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_e;

    localparam int CLS_W     = 8;
    localparam int CLS_MOV8  = 0;
    localparam int CLS_SETAB = 1;
    localparam int CLS_ALU   = 2;
    localparam int CLS_LDST  = 3;
    localparam int CLS_MOV16 = 4;
    localparam int CLS_INC16 = 5;
    localparam int CLS_HALT  = 6;
    localparam int CLS_GOTO  = 7;

    localparam logic [7:0] OP_MASK_TOP2    = 8'hC0;
    localparam logic [7:0] OP_MASK_TOP4    = 8'hF0;
    localparam logic [7:0] OP_MATCH_MOV8   = 8'h00;
    localparam logic [7:0] OP_MATCH_SETAB  = 8'h40;
    localparam logic [7:0] OP_MATCH_GOTO   = 8'hC0;
    localparam logic [7:0] OP_MATCH_ALU    = 8'h80;
    localparam logic [7:0] OP_MATCH_LDST   = 8'h90;
    localparam logic [7:0] OP_MATCH_MOV16  = 8'hA0;
    localparam logic [7:0] OP_INC16        = 8'hB0;
    localparam logic [7:0] OP_HALT_DEFAULT = 8'hAE;

    localparam int DEF_MAX_STEPS   = 24;
    localparam int DEF_ABORT_SHORT = 8;
    localparam int DEF_ABORT_MOV16 = 10;
    localparam int DEF_ABORT_LDST  = 12;
    localparam int DEF_ABORT_INC16 = 14;
    localparam int DEF_ABORT_GOTO  = 24;

    // HALT always finishes on step 8, independent of the configurable end steps.
    localparam int HALT_END_STEP   = 8;
    localparam int FETCH_LAST_STEP = 4;
    localparam int ALU_COND_STEP   = 5;
    localparam int INST_LATCH_STEP = 2;

endpackage

// File: rtl/seq_opcode_class.sv
// Combinational opcode decoder: one-hot instruction class plus the step on which
// that instruction ends. An all-zero class marks an illegal opcode.
module seq_opcode_class
    import seq_pkg::*;
#(
    parameter int         STEP_W      = 5,
    parameter int         ABORT_SHORT = DEF_ABORT_SHORT,
    parameter int         ABORT_MOV16 = DEF_ABORT_MOV16,
    parameter int         ABORT_LDST  = DEF_ABORT_LDST,
    parameter int         ABORT_INC16 = DEF_ABORT_INC16,
    parameter int         ABORT_GOTO  = DEF_ABORT_GOTO,
    parameter logic [7:0] HALT_OP     = OP_HALT_DEFAULT
) (
    input  logic [7:0]        opcode_i,
    output logic [CLS_W-1:0]  cls_o,
    output logic [STEP_W-1:0] end_step_o,
    output logic              illegal_o
);

    always_comb begin
        cls_o      = '0;
        end_step_o = STEP_W'(ABORT_SHORT);
        // Exact-match opcodes first so they win over their enclosing groups.
        if (opcode_i == HALT_OP) begin
            cls_o[CLS_HALT] = 1'b1;
            end_step_o      = STEP_W'(HALT_END_STEP);
        end else if (opcode_i == OP_INC16) begin
            cls_o[CLS_INC16] = 1'b1;
            end_step_o       = STEP_W'(ABORT_INC16);
        end else if ((opcode_i & OP_MASK_TOP2) == OP_MATCH_MOV8) begin
            cls_o[CLS_MOV8] = 1'b1;
        end else if ((opcode_i & OP_MASK_TOP2) == OP_MATCH_SETAB) begin
            cls_o[CLS_SETAB] = 1'b1;
        end else if ((opcode_i & OP_MASK_TOP2) == OP_MATCH_GOTO) begin
            cls_o[CLS_GOTO] = 1'b1;
            end_step_o      = STEP_W'(ABORT_GOTO);
        end else if ((opcode_i & OP_MASK_TOP4) == OP_MATCH_ALU) begin
            cls_o[CLS_ALU] = 1'b1;
        end else if ((opcode_i & OP_MASK_TOP4) == OP_MATCH_LDST) begin
            cls_o[CLS_LDST] = 1'b1;
            end_step_o      = STEP_W'(ABORT_LDST);
        end else if ((opcode_i & OP_MASK_TOP4) == OP_MATCH_MOV16) begin
            cls_o[CLS_MOV16] = 1'b1;
            end_step_o       = STEP_W'(ABORT_MOV16);
        end
    end

    assign illegal_o = ~|cls_o;

endmodule

// File: rtl/seq_pulse_sequencer.sv
// Instruction sequencer: internal step counter, fetch strobes, opcode latch and
// classification, per-class end step, run/single-step control and HALT handling.
module seq_pulse_sequencer
    import seq_pkg::*;
#(
    parameter int         MAX_STEPS   = DEF_MAX_STEPS,
    parameter int         STEP_W      = $clog2(MAX_STEPS + 1),
    parameter int         ABORT_SHORT = DEF_ABORT_SHORT,
    parameter int         ABORT_MOV16 = DEF_ABORT_MOV16,
    parameter int         ABORT_LDST  = DEF_ABORT_LDST,
    parameter int         ABORT_INC16 = DEF_ABORT_INC16,
    parameter int         ABORT_GOTO  = DEF_ABORT_GOTO,
    parameter logic [7:0] HALT_OP     = OP_HALT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              single_step,
    input  logic              step_req,
    input  logic [7:0]        inst_in,
    input  logic [2:0]        alu_flags,
    output logic [STEP_W-1:0] step,
    output logic [7:0]        inst_q,
    output logic [CLS_W-1:0]  cls,
    output logic              mem_read,
    output logic              sel_pc,
    output logic              ld_inst,
    output logic              ld_inc,
    output logic              sel_inc,
    output logic              ld_pc,
    output logic              ld_cond,
    output logic [2:0]        cond_q,
    output logic              abort,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output seq_state_e        dbg_state
);

    if (ABORT_SHORT < 8 || ABORT_SHORT > MAX_STEPS ||
        ABORT_MOV16 < 8 || ABORT_MOV16 > MAX_STEPS ||
        ABORT_LDST  < 8 || ABORT_LDST  > MAX_STEPS ||
        ABORT_INC16 < 8 || ABORT_INC16 > MAX_STEPS ||
        ABORT_GOTO  < 8 || ABORT_GOTO  > MAX_STEPS) begin : g_bad_abort
        $error("seq_pulse_sequencer: every abort step must lie within 8..MAX_STEPS");
    end

    localparam logic [STEP_W-1:0] S_ONE   = STEP_W'(1);
    localparam logic [STEP_W-1:0] S_TWO   = STEP_W'(2);
    localparam logic [STEP_W-1:0] S_THREE = STEP_W'(3);
    localparam logic [STEP_W-1:0] S_LATCH = STEP_W'(INST_LATCH_STEP);
    localparam logic [STEP_W-1:0] S_FLAST = STEP_W'(FETCH_LAST_STEP);
    localparam logic [STEP_W-1:0] S_COND  = STEP_W'(ALU_COND_STEP);

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] end_q;
    logic [7:0]        opcode_q;
    logic [CLS_W-1:0]  cls_q;
    logic [2:0]        flags_q;
    logic              req_q;
    logic              req_edge;
    logic              mem_read_q, sel_pc_q, ld_inst_q, ld_inc_q, sel_inc_q, ld_pc_q;
    logic              ld_cond_q, abort_q, busy_q, halted_q, illegal_q;
    logic              fetch_d;

    logic [CLS_W-1:0]  dec_cls;
    logic [STEP_W-1:0] dec_end;
    logic              dec_illegal;

    seq_opcode_class #(
        .STEP_W      (STEP_W),
        .ABORT_SHORT (ABORT_SHORT),
        .ABORT_MOV16 (ABORT_MOV16),
        .ABORT_LDST  (ABORT_LDST),
        .ABORT_INC16 (ABORT_INC16),
        .ABORT_GOTO  (ABORT_GOTO),
        .HALT_OP     (HALT_OP)
    ) u_class (
        .opcode_i   (inst_in),
        .cls_o      (dec_cls),
        .end_step_o (dec_end),
        .illegal_o  (dec_illegal)
    );

    assign req_edge = step_req & ~req_q;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE: begin
                if (run && (!single_step || req_edge)) begin
                    state_d = ST_FETCH;
                    step_d  = S_ONE;
                end
            end
            ST_FETCH: begin
                step_d = step_q + S_ONE;
                if (step_q == S_FLAST) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (step_q == end_q) begin
                    if (cls_q[CLS_HALT]) begin
                        state_d = ST_HALTED;
                        step_d  = '0;
                    end else if (!run || single_step) begin
                        state_d = ST_IDLE;
                        step_d  = '0;
                    end else begin
                        state_d = ST_FETCH;
                        step_d  = S_ONE;
                    end
                end else begin
                    step_d = step_q + S_ONE;
                end
            end
            ST_HALTED: begin
                step_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
    end

    assign fetch_d = (state_d == ST_FETCH);

    // Strobes are computed from the next step so they are registered yet aligned with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            end_q      <= STEP_W'(ABORT_SHORT);
            opcode_q   <= '0;
            cls_q      <= '0;
            flags_q    <= '0;
            req_q      <= 1'b0;
            mem_read_q <= 1'b0;
            sel_pc_q   <= 1'b0;
            ld_inst_q  <= 1'b0;
            ld_inc_q   <= 1'b0;
            sel_inc_q  <= 1'b0;
            ld_pc_q    <= 1'b0;
            ld_cond_q  <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            req_q      <= step_req;
            mem_read_q <= fetch_d && (step_d == S_ONE || step_d == S_TWO);
            sel_pc_q   <= fetch_d && (step_d == S_ONE || step_d == S_TWO);
            ld_inst_q  <= fetch_d && (step_d == S_TWO);
            ld_inc_q   <= fetch_d && (step_d == S_TWO);
            sel_inc_q  <= fetch_d && (step_d == S_THREE || step_d == S_FLAST);
            ld_pc_q    <= fetch_d && (step_d == S_FLAST);
            ld_cond_q  <= (state_d == ST_EXEC) && (step_d == S_COND) && cls_q[CLS_ALU];
            abort_q    <= (state_d == ST_EXEC) && (step_d == end_q);
            busy_q     <= (state_d == ST_FETCH) || (state_d == ST_EXEC);
            halted_q   <= (state_d == ST_HALTED);
            if (state_q == ST_FETCH && step_q == S_LATCH) begin
                opcode_q  <= inst_in;
                cls_q     <= dec_cls;
                end_q     <= dec_end;
                illegal_q <= illegal_q | dec_illegal;
            end
            if (state_q == ST_EXEC && step_q == S_COND && cls_q[CLS_ALU]) begin
                flags_q <= alu_flags;
            end
        end
    end

    assign step      = step_q;
    assign inst_q    = opcode_q;
    assign cls       = cls_q;
    assign mem_read  = mem_read_q;
    assign sel_pc    = sel_pc_q;
    assign ld_inst   = ld_inst_q;
    assign ld_inc    = ld_inc_q;
    assign sel_inc   = sel_inc_q;
    assign ld_pc     = ld_pc_q;
    assign ld_cond   = ld_cond_q;
    assign cond_q    = flags_q;
    assign abort     = abort_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_pulse_sequencer.sv
// Directed bench for seq_pulse_sequencer: fetch strobes, ALU flag capture,
// per-class end steps, single-step control, illegal/HALT handling and async reset.
module tb_seq_pulse_sequencer;
    import seq_pkg::*;

    localparam int STEP_W = 5;

    logic              clock = 1'b0;
    logic              reset;
    logic              run;
    logic              single_step;
    logic              step_req;
    logic [7:0]        inst_in;
    logic [2:0]        alu_flags;
    logic [STEP_W-1:0] step;
    logic [7:0]        inst_q;
    logic [7:0]        cls;
    logic              mem_read, sel_pc, ld_inst, ld_inc, sel_inc, ld_pc;
    logic              ld_cond;
    logic [2:0]        cond_q;
    logic              abort, busy, halted, illegal;
    seq_state_e        dbg_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    seq_pulse_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .single_step (single_step),
        .step_req    (step_req),
        .inst_in     (inst_in),
        .alu_flags   (alu_flags),
        .step        (step),
        .inst_q      (inst_q),
        .cls         (cls),
        .mem_read    (mem_read),
        .sel_pc      (sel_pc),
        .ld_inst     (ld_inst),
        .ld_inc      (ld_inc),
        .sel_inc     (sel_inc),
        .ld_pc       (ld_pc),
        .ld_cond     (ld_cond),
        .cond_q      (cond_q),
        .abort       (abort),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .dbg_state   (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Ticks until abort is seen or 40 cycles elapse; returns cycles ticked.
    task automatic wait_abort(output int n);
        n = 0;
        while (abort !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({step, inst_q, cls, mem_read, sel_pc, ld_inst, ld_inc, sel_inc,
                    ld_pc, ld_cond, cond_q, abort, busy, halted, illegal});
    endfunction

    function automatic logic [5:0] strobes();
        return {mem_read, sel_pc, ld_inst, ld_inc, sel_inc, ld_pc};
    endfunction

    initial begin
        logic [5:0] fetch_exp [1:4];
        logic [7:0] ops  [4];
        logic [7:0] clss [4];
        int         ends [4];
        int         n;
        int         pre;

        fetch_exp = '{6'b110000, 6'b111100, 6'b000010, 6'b000011};
        ops       = '{8'h90, 8'hA0, 8'hB0, 8'hC0};
        clss      = '{8'h08, 8'h10, 8'h20, 8'h80};
        ends      = '{12, 10, 14, 24};

        reset = 1'b1; run = 1'b0; single_step = 1'b0; step_req = 1'b0;
        inst_in = 8'h00; alu_flags = 3'b000;
        tick(); tick();
        check("reset_outs", all_outs(), 64'd0);
        reset = 1'b0;
        tick();
        check("idle_step", 64'(step), 64'd0);
        check("idle_state", 64'(dbg_state), 64'(ST_IDLE));

        // Free-run MOV8, one full instruction step by step
        run = 1'b1; inst_in = 8'h12;
        for (int s = 1; s <= 8; s++) begin
            tick();
            check($sformatf("mov8_step%0d", s), 64'(step), 64'(s));
            check($sformatf("mov8_strobes%0d", s), 64'(strobes()),
                  (s <= 4) ? 64'(fetch_exp[s]) : 64'd0);
            check($sformatf("mov8_abort%0d", s), 64'(abort), 64'(s == 8));
            check($sformatf("mov8_busy%0d", s), 64'(busy), 64'd1);
            if (s >= 3) check($sformatf("mov8_cls%0d", s), 64'(cls), 64'h01);
        end
        check("mov8_inst_q", 64'(inst_q), 64'h12);

        // Back-to-back into ALU 81 with flags 101
        inst_in = 8'h81; alu_flags = 3'b101;
        tick();
        check("b2b_step1", 64'(step), 64'd1);
        for (int s = 2; s <= 8; s++) begin
            tick();
            check($sformatf("alu_step%0d", s), 64'(step), 64'(s));
            check($sformatf("alu_ld_cond%0d", s), 64'(ld_cond), 64'(s == 5));
            if (s == 5) check("alu_cond_before", 64'(cond_q), 64'd0);
        end
        check("alu_cls", 64'(cls), 64'h04);
        check("alu_cond_after", 64'(cond_q), 64'b101);
        run = 1'b0;
        tick();
        check("alu_stop_step", 64'(step), 64'd0);
        check("alu_stop_busy", 64'(busy), 64'd0);

        // Class end steps, back-to-back; run drops mid-GOTO
        run = 1'b1; inst_in = ops[0];
        tick();
        check("sweep_start", 64'(step), 64'd1);
        for (int i = 0; i < 4; i++) begin
            pre = 0;
            if (i == 3) begin
                repeat (3) tick();
                pre = 3;
                run = 1'b0;
            end
            wait_abort(n);
            check($sformatf("sweep_abort_%0h", ops[i]), 64'({abort, step}),
                  64'({1'b1, 5'(ends[i])}));
            check($sformatf("sweep_cycles_%0h", ops[i]), 64'(pre + n + 1), 64'(ends[i]));
            check($sformatf("sweep_cls_%0h", ops[i]), 64'(cls), 64'(clss[i]));
            if (i < 3) begin
                inst_in = ops[i + 1];
                tick();
                check($sformatf("sweep_b2b_%0d", i), 64'(step), 64'd1);
            end
        end
        tick();
        check("sweep_idle", 64'(step), 64'd0);
        check("sweep_idle_state", 64'(dbg_state), 64'(ST_IDLE));

        // Single-step: three requests, the middle one while busy
        single_step = 1'b1; run = 1'b1; inst_in = 8'h12;
        repeat (3) tick();
        check("ss_wait", 64'(step), 64'd0);
        step_req = 1'b1;
        tick();
        check("ss_first_start", 64'(step), 64'd1);
        step_req = 1'b0;
        tick(); tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("ss_mid_req", 64'(step), 64'd4);
        wait_abort(n);
        check("ss_first_abort", 64'(step), 64'd8);
        tick();
        check("ss_gap", 64'(step), 64'd0);
        repeat (5) tick();
        check("ss_no_queue", 64'(step), 64'd0);
        step_req = 1'b1;
        tick();
        check("ss_second_start", 64'(step), 64'd1);
        step_req = 1'b0;
        wait_abort(n);
        check("ss_second_abort", 64'(step), 64'd8);
        tick();
        repeat (4) tick();
        check("ss_final_idle", 64'(step), 64'd0);

        // Illegal opcode B5
        single_step = 1'b0; run = 1'b1; inst_in = 8'hB5;
        check("ill_before", 64'(illegal), 64'd0);
        tick(); tick();
        check("ill_step2", 64'({step, illegal}), 64'({5'd2, 1'b0}));
        tick();
        check("ill_step3", 64'({step, illegal}), 64'({5'd3, 1'b1}));
        check("ill_cls", 64'(cls), 64'd0);
        wait_abort(n);
        check("ill_abort", 64'({abort, step}), 64'({1'b1, 5'd8}));
        run = 1'b0;
        tick();
        check("ill_sticky", 64'({step, illegal}), 64'({5'd0, 1'b1}));

        // HALT
        run = 1'b1; inst_in = 8'hAE;
        tick();
        wait_abort(n);
        check("halt_abort", 64'({abort, step}), 64'({1'b1, 5'd8}));
        check("halt_cls", 64'(cls), 64'h40);
        tick();
        check("halt_status", 64'({step, busy, halted}), 64'({5'd0, 1'b0, 1'b1}));
        check("halt_state", 64'(dbg_state), 64'(ST_HALTED));
        single_step = 1'b1; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        repeat (3) tick();
        check("halt_ignores_req", 64'({step, halted}), 64'({5'd0, 1'b1}));

        // Reset clears HALTED, then reset mid-GOTO at step 6
        reset = 1'b1;
        #1;
        check("halt_reset", all_outs(), 64'd0);
        tick();
        reset = 1'b0; single_step = 1'b0; run = 1'b1;
        inst_in = 8'h81; alu_flags = 3'b011;
        tick();
        wait_abort(n);
        inst_in = 8'hC0;
        tick();
        check("goto_start", 64'(step), 64'd1);
        repeat (5) tick();
        check("goto_step6", 64'({step, cls, cond_q}), 64'({5'd6, 8'h80, 3'b011}));
        reset = 1'b1;
        #1;
        check("goto_reset_outs", all_outs(), 64'd0);
        check("goto_reset_state", 64'(dbg_state), 64'(ST_IDLE));
        tick(); tick();
        check("goto_reset_held", all_outs(), 64'd0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
